bus_arbiter: RTL and testbench

- Shares the single 8-bit data / 16-bit address memory bus between two masters: master 0 (CPU fetch/execute port) and master 1 (DMA/video port).
- Performs one byte transaction per grant: address setup, strobe with wait states, data capture, then a one-cycle ack.
- Sits between the cpu core and the memory/peripheral decode.
- Simultaneous requests are resolved round-robin.

---
 rtl/bus_pkg.sv | 20 ++
 rtl/bus_rr_pick.sv | 33 +++
 rtl/bus_arbiter.sv | 135 +++++++++++++
 tb/tb_bus_arbiter.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared types and widths for the two-master memory bus arbiter.
// Widths match the 8-bit data / 16-bit address system bus.
package bus_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } arb_state_t;

    typedef logic master_id_t;

    localparam master_id_t M0 = 1'b0;
    localparam master_id_t M1 = 1'b1;

endpackage

// File: rtl/bus_rr_pick.sv
// Combinational winner select for the two bus masters: round-robin on a tie,
// with an optional sticky grant to a locked owner (BUS_ARBITER_LOCK_EN).
module bus_rr_pick
    import bus_pkg::*;
(
    input  logic [1:0] req,
    input  master_id_t last_grant,
`ifdef BUS_ARBITER_LOCK_EN
    input  logic       lock_hold,
    input  master_id_t owner,
`endif
    output logic       grant_vld,
    output master_id_t grant_id
);

    always_comb begin
        grant_vld = |req;
        grant_id  = M0;
        case (req)
            2'b01:   grant_id = M0;
            2'b10:   grant_id = M1;
            2'b11:   grant_id = ~last_grant;
            default: grant_id = M0;
        endcase
`ifdef BUS_ARBITER_LOCK_EN
        // A locked owner keeps the bus for its follow-on byte if it still asks.
        if (lock_hold && req[owner]) begin
            grant_id = owner;
        end
`endif
    end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master byte bus arbiter: IDLE->SETUP->ACCESS->DONE, ack in cycle 3+WAIT_STATES.
// Requesters hold req until ack; the loser waits in IDLE. Optional lock via BUS_ARBITER_LOCK_EN.
module bus_arbiter #(
    parameter int ADDR_W      = bus_pkg::ADDR_W,
    parameter int DATA_W      = bus_pkg::DATA_W,
    parameter int WAIT_STATES = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_ack,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_ack,
`ifdef BUS_ARBITER_LOCK_EN
    input  logic              m0_lock,
    input  logic              m1_lock,
`endif
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wdata_oe,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              mem_r,
    output logic              mem_w
);

    import bus_pkg::*;

    arb_state_t        state;
    master_id_t        owner;
    master_id_t        last_grant;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [3:0]        wait_cnt;
    logic              grant_vld;
    master_id_t        grant_id;

`ifdef BUS_ARBITER_LOCK_EN
    logic              lock_hold;
    logic              owner_lock;

    assign owner_lock = (owner == M1) ? m1_lock : m0_lock;
`endif

    bus_rr_pick u_pick (
        .req        ({m1_req, m0_req}),
        .last_grant (last_grant),
`ifdef BUS_ARBITER_LOCK_EN
        .lock_hold  (lock_hold),
        .owner      (owner),
`endif
        .grant_vld  (grant_vld),
        .grant_id   (grant_id)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            owner      <= M0;
            last_grant <= M1;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wait_cnt   <= '0;
            m0_rdata   <= '0;
            m1_rdata   <= '0;
`ifdef BUS_ARBITER_LOCK_EN
            lock_hold  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        owner   <= grant_id;
                        we_q    <= (grant_id == M1) ? m1_we    : m0_we;
                        addr_q  <= (grant_id == M1) ? m1_addr  : m0_addr;
                        wdata_q <= (grant_id == M1) ? m1_wdata : m0_wdata;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    wait_cnt <= 4'(WAIT_STATES);
                    state    <= ACCESS;
                end
                ACCESS: begin
                    if (wait_cnt == 4'd0) begin
                        // Read data is taken on the last strobe edge, not in DONE.
                        if (!we_q) begin
                            if (owner == M1) begin
                                m1_rdata <= mem_rdata;
                            end else begin
                                m0_rdata <= mem_rdata;
                            end
                        end
                        state <= DONE;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                DONE: begin
`ifdef BUS_ARBITER_LOCK_EN
                    if (owner_lock) begin
                        lock_hold <= 1'b1;
                    end else begin
                        lock_hold  <= 1'b0;
                        last_grant <= owner;
                    end
`else
                    last_grant <= owner;
`endif
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Strobes decode straight from state so a reset drops them without waiting for a clock.
    assign mem_addr     = addr_q;
    assign mem_wdata    = wdata_q;
    assign mem_r        = (state == ACCESS) && !we_q;
    assign mem_w        = (state == ACCESS) && we_q;
    assign mem_wdata_oe = mem_w;
    assign m0_ack       = (state == DONE) && (owner == M0);
    assign m1_ack       = (state == DONE) && (owner == M1);

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: transaction-level model checked every cycle plus directed literal checks.
module tb_bus_arbiter;

    localparam int WS  = 1;
    localparam int WS3 = 3;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
    logic [15:0] m0_addr = 0, m1_addr = 0;
    logic [7:0]  m0_wdata = 0, m1_wdata = 0, mem_rdata = 0;
    logic [7:0]  m0_rdata, m1_rdata, mem_wdata;
    logic        m0_ack, m1_ack, mem_wdata_oe, mem_r, mem_w;
    logic [15:0] mem_addr;
    logic        m0_lock = 0, m1_lock = 0;

    // second instance with three wait states, only master 0 used
    logic        w_req = 0;
    logic [15:0] w_addr = 0;
    logic [7:0]  w_mem_rdata = 0;
    logic [7:0]  w_m0_rdata, w_m1_rdata, w_mem_wdata;
    logic        w_m0_ack, w_m1_ack, w_oe, w_mem_r, w_mem_w;
    logic [15:0] w_mem_addr;

    always #5 clk = ~clk;

    bus_arbiter #(.WAIT_STATES(WS)) dut (
        .clk(clk), .reset(reset),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_rdata(m0_rdata), .m0_ack(m0_ack),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_rdata(m1_rdata), .m1_ack(m1_ack),
`ifdef BUS_ARBITER_LOCK_EN
        .m0_lock(m0_lock), .m1_lock(m1_lock),
`endif
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wdata_oe(mem_wdata_oe),
        .mem_rdata(mem_rdata), .mem_r(mem_r), .mem_w(mem_w)
    );

    bus_arbiter #(.WAIT_STATES(WS3)) dut3 (
        .clk(clk), .reset(reset),
        .m0_req(w_req), .m0_we(1'b0), .m0_addr(w_addr), .m0_wdata(8'h00),
        .m0_rdata(w_m0_rdata), .m0_ack(w_m0_ack),
        .m1_req(1'b0), .m1_we(1'b0), .m1_addr(16'h0000), .m1_wdata(8'h00),
        .m1_rdata(w_m1_rdata), .m1_ack(w_m1_ack),
`ifdef BUS_ARBITER_LOCK_EN
        .m0_lock(1'b0), .m1_lock(1'b0),
`endif
        .mem_addr(w_mem_addr), .mem_wdata(w_mem_wdata), .mem_wdata_oe(w_oe),
        .mem_rdata(w_mem_rdata), .mem_r(w_mem_r), .mem_w(w_mem_w)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    bit          busy = 0;
    int          t0 = 0, own = 0, last = 1, mk = 0, win = 0;
    bit          mwe = 0;
    logic [15:0] maddr = 0;
    logic [7:0]  mwd = 0;
    logic [7:0]  exp_rd [2] = '{8'h00, 8'h00};
    bit          locked = 0;
    int          lock_own = 0;
    logic        e_r, e_w, e_a0, e_a1;

    always @(negedge clk) begin
        if (reset) begin
            busy = 0; last = 1; locked = 0;
            exp_rd[0] = 8'h00; exp_rd[1] = 8'h00;
            check("rst_strobes", {mem_r, mem_w, mem_wdata_oe, m0_ack, m1_ack}, 0);
            check("rst_rdata", {m0_rdata, m1_rdata}, 0);
        end else begin
            mk = busy ? (cyc - t0) : -1;
            e_r = 0; e_w = 0; e_a0 = 0; e_a1 = 0;
            if (busy && mk >= 2 && mk <= 2 + WS) begin
                e_r = !mwe;
                e_w = mwe;
            end
            if (busy && mk == 3 + WS) begin
                e_a0 = (own == 0);
                e_a1 = (own == 1);
            end
            check("mdl_mem_r", mem_r, e_r);
            check("mdl_mem_w", mem_w, e_w);
            check("mdl_oe", mem_wdata_oe, e_w);
            check("mdl_m0_ack", m0_ack, e_a0);
            check("mdl_m1_ack", m1_ack, e_a1);
            check("mdl_m0_rdata", m0_rdata, exp_rd[0]);
            check("mdl_m1_rdata", m1_rdata, exp_rd[1]);
            if (busy && mk >= 1 && mk <= 2 + WS) check("mdl_addr", mem_addr, maddr);
            if (busy && mwe && mk >= 2 && mk <= 2 + WS) check("mdl_wdata", mem_wdata, mwd);

            if (busy && mk == 2 + WS && !mwe) exp_rd[own] = mem_rdata;
            if (busy && mk == 3 + WS) begin
                busy = 0;
`ifdef BUS_ARBITER_LOCK_EN
                if ((own == 1) ? m1_lock : m0_lock) begin
                    locked = 1; lock_own = own;
                end else begin
                    locked = 0; last = own;
                end
`else
                last = own;
`endif
            end else if (!busy && (m0_req || m1_req)) begin
                if (m0_req && m1_req) win = 1 - last;
                else if (m0_req) win = 0;
                else win = 1;
`ifdef BUS_ARBITER_LOCK_EN
                if (locked && ((lock_own == 1) ? m1_req : m0_req)) win = lock_own;
`endif
                busy = 1; t0 = cyc; own = win;
                mwe   = (win == 1) ? m1_we : m0_we;
                maddr = (win == 1) ? m1_addr : m0_addr;
                mwd   = (win == 1) ? m1_wdata : m0_wdata;
            end
        end
    end

    // ---------------- directed transaction with trace ----------------
    int          tr_ack_k;
    logic [15:0] tr_r, tr_w, tr_oe;
    logic [15:0] tr_addr [16];
    logic [7:0]  tr_wd [16];
    logic [7:0]  tr_rd;
    logic        tr_other;

    task automatic txn(input int m, input logic we, input logic [15:0] a, input logic [7:0] d);
        if (m == 0) begin
            m0_we = we; m0_addr = a; m0_wdata = d; m0_req = 1;
        end else begin
            m1_we = we; m1_addr = a; m1_wdata = d; m1_req = 1;
        end
        tr_ack_k = -1; tr_r = 0; tr_w = 0; tr_oe = 0; tr_rd = 0; tr_other = 0;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            tr_r[k] = mem_r; tr_w[k] = mem_w; tr_oe[k] = mem_wdata_oe;
            tr_addr[k] = mem_addr; tr_wd[k] = mem_wdata;
            if ((m == 0) ? m1_ack : m0_ack) tr_other = 1;
            if ((m == 0) ? m0_ack : m1_ack) begin
                tr_ack_k = k;
                tr_rd = (m == 0) ? m0_rdata : m1_rdata;
                break;
            end
        end
        @(posedge clk); #1;
        m0_req = 0; m1_req = 0;
    endtask

    int ack_who [4];
    int ack_at [4];
    int n_ack;
    int start_cyc;
    int rcount;
    int w_ack_k;
    bit seen;

    initial begin
        #12;
        check("reset_mem_addr", mem_addr, 16'h0000);
        check("reset_mem_wdata", mem_wdata, 8'h00);
        check("reset_outs", {mem_r, mem_w, mem_wdata_oe, m0_ack, m1_ack}, 0);
        check("reset_rdata", {m0_rdata, m1_rdata}, 0);
        check("reset_dut3_r", w_mem_r, 0);
        @(posedge clk); #1 reset = 0;
        @(posedge clk); #1;

        // single read by m0
        mem_rdata = 8'hA5;
        txn(0, 0, 16'h2000, 8'h00);
        check("rd_ack_cycle", tr_ack_k, 4);
        check("rd_mem_r_trace", tr_r, 16'h000C);
        check("rd_rdata", tr_rd, 8'hA5);
        check("rd_no_m1_ack", tr_other, 0);
        check("rd_addr_setup", tr_addr[1], 16'h2000);
        @(posedge clk); #1;

        // single write by m1
        mem_rdata = 8'h00;
        txn(1, 1, 16'h1234, 8'h3C);
        check("wr_ack_cycle", tr_ack_k, 4);
        check("wr_mem_w_trace", tr_w, 16'h000C);
        check("wr_oe_trace", tr_oe, 16'h000C);
        check("wr_addr_setup", tr_addr[1], 16'h1234);
        check("wr_addr_access", tr_addr[3], 16'h1234);
        check("wr_wdata_access", {tr_wd[2], tr_wd[3]}, 16'h3C3C);
        check("wr_m1_rdata_kept", tr_rd, 8'h00);
        @(posedge clk); #1;

        // m1 read, then m0 write leaves m0 rdata intact
        mem_rdata = 8'h5A;
        txn(1, 0, 16'hBEEF, 8'h00);
        check("rd1_rdata", tr_rd, 8'h5A);
        txn(0, 1, 16'h0042, 8'h99);
        check("wr0_rdata_kept", tr_rd, 8'hA5);
        check("wr0_no_m1_ack", tr_other, 0);
        @(posedge clk); #1;

        // three wait states on the second instance
        w_mem_rdata = 8'hC3; w_addr = 16'h0F00; w_req = 1;
        rcount = 0; w_ack_k = -1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            if (w_mem_r) rcount++;
            if (w_m0_ack) begin
                w_ack_k = k;
                check("ws3_rdata", w_m0_rdata, 8'hC3);
                break;
            end
        end
        check("ws3_strobe_len", rcount, 4);
        check("ws3_ack_cycle", w_ack_k, 6);
        @(posedge clk); #1 w_req = 0;
        @(posedge clk); #1;

        // reset during an m0 write access
        m0_we = 1; m0_addr = 16'h4444; m0_wdata = 8'h77; m0_req = 1;
        seen = 0;
        for (int k = 0; k < 10 && !seen; k++) begin
            @(negedge clk);
            if (mem_w) seen = 1;
        end
        check("rstmid_reached_access", seen, 1);
        @(posedge clk); #1;
        check("rstmid_pre_mem_w", mem_w, 1);
        #1 reset = 1;
        #1;
        check("rstmid_mem_w_drop", {mem_w, mem_wdata_oe}, 0);
        check("rstmid_no_ack", m0_ack, 0);
        m0_req = 0; m0_we = 0;
        @(posedge clk); @(posedge clk); #1 reset = 0;
        @(posedge clk); #1;

        // contention after reset: m0, m1, m0, m1, acks 5 apart
        mem_rdata = 8'h11;
        m0_we = 0; m0_addr = 16'h0100; m1_we = 0; m1_addr = 16'h0200;
        m0_req = 1; m1_req = 1; start_cyc = cyc; n_ack = 0;
        for (int k = 0; k < 40 && n_ack < 4; k++) begin
            @(negedge clk);
            if (m0_ack || m1_ack) begin
                ack_who[n_ack] = m1_ack ? 1 : 0;
                ack_at[n_ack] = cyc;
                n_ack++;
            end
        end
        @(posedge clk); #1 m0_req = 0; m1_req = 0;
        check("cont_ack_count", n_ack, 4);
        check("cont_order", {ack_who[0][3:0], ack_who[1][3:0], ack_who[2][3:0], ack_who[3][3:0]}, 16'h0101);
        check("cont_first_ack", ack_at[0] - start_cyc, 4);
        check("cont_gap1", ack_at[1] - ack_at[0], 5);
        check("cont_gap3", ack_at[3] - ack_at[2], 5);
        @(posedge clk); #1;

`ifdef BUS_ARBITER_LOCK_EN
        // m0 locks its first byte, so it gets the bus twice before m1
        m0_lock = 1; m0_req = 1; m1_req = 1; n_ack = 0;
        for (int k = 0; k < 40 && n_ack < 3; k++) begin
            @(negedge clk);
            if (m0_ack || m1_ack) begin
                ack_who[n_ack] = m1_ack ? 1 : 0;
                n_ack++;
                if (n_ack == 1) begin
                    @(posedge clk); #1 m0_lock = 0;
                end
            end
        end
        @(posedge clk); #1 m0_req = 0; m1_req = 0;
        check("lock_ack_count", n_ack, 3);
        check("lock_order", {ack_who[0][3:0], ack_who[1][3:0], ack_who[2][3:0]}, 12'h001);
        @(posedge clk); #1;
`endif

        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, required completion");
        $fatal(1, "timeout");
    end

endmodule
